data_ram_responder: RTL and testbench
=====================================

Name: data_ram_responder

Overview:
- Responder end of the CPU data-memory interface (read enable, write enable, byte address, byte select, store data, load data).
- Replaces the zero-latency data RAM with a multi-cycle responder that holds the CPU with a stall signal for a configurable latency, then commits the write or returns the load word.
- Sits between the CPU memory stage and a word-organised storage array.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in storage (1024 words = 4 KiB).
- LATENCY, 2, number of cycles `o_stall` is asserted per accepted request; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: 0 = reset.
- i_readEnable  in  1  load request.
- i_writeEnable  in  1  store request.
- i_addr  in  32  byte address; `addr[1:0]` is ignored because lanes come from `i_sel`.
- i_sel  in  4  byte-lane enables; bit n selects bits [8n+7:8n].
- i_storeData  in  32  store word, lane-aligned.
- o_loadData  out  32  load word; valid only in the RESP cycle.
- o_stall  out  1  CPU must hold the pipeline and the request stable.
- o_respValid  out  1  one-cycle pulse when the request completes.
- o_addrError  out  1  one-cycle pulse together with `o_respValid` when the request was out of range.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset values: state IDLE, counter 0, `o_loadData` 0, `o_stall` 0, `o_respValid` 0, `o_addrError` 0. The storage array is not cleared.
- Reset asserted mid-operation: the request is dropped, no write is committed, and the block returns to IDLE.
- IDLE with no request: `o_stall`=0.
- IDLE with `i_readEnable` or `i_writeEnable` high:
  - `o_stall`=1 combinationally in that cycle.
  - On the edge: latch op, word index, sel, store data and out-of-range flag.
  - Next state is RESP if LATENCY==1; otherwise BUSY with counter = LATENCY-2.
- BUSY: `o_stall`=1. Go to RESP when the counter is 0, else decrement.
- Stall timing: `o_stall` is high for exactly LATENCY consecutive cycles, counting the request-presented cycle.
- RESP (one cycle):
  - `o_stall`=0 and `o_respValid`=1.
  - Read: `o_loadData` = stored word, all 4 bytes regardless of sel.
  - Write: at the end of the RESP cycle, only the lanes selected by the latched sel are written; `o_loadData`=0.
  - Next state IDLE. The CPU advances on the same edge, so a new request is first seen in the following IDLE cycle. Back-to-back requests therefore have one non-stalled gap cycle.
- Word index = `addr[DEPTH_LOG2+1:2]`.
- Out-of-range: any of `addr[31:DEPTH_LOG2+2]` nonzero. The request still takes full latency. In RESP, `o_addrError`=1, the write is suppressed and `o_loadData`=0. There is no wrap-around.
- Both enables high: treated as a write; the read is ignored.
- Write with sel=0000: takes full latency, modifies nothing, `o_respValid` still pulses.
- Request inputs changing or dropping during BUSY is a protocol violation. The latched request completes unchanged and the inputs are ignored until IDLE.
- `o_loadData` is registered, captured on the edge into RESP, and cleared to 0 in every other cycle.
- Read-after-write to the same word in consecutive requests returns the new data, since the write commits before the next request is accepted.

Decomposition:
- Shared package: WORD_BUS width (32), MEM_ADDR_BUS width (32), MEM_SEL_BUS width (4), state enum {IDLE, BUSY, RESP}, LATENCY legal-range constants.
- One sub-module, ram_word_array: a 2^DEPTH_LOG2 x 32 array with a synchronous byte-lane-masked write port and an asynchronous read port, no reset. The FSM, counter and range check stay in data_ram_responder.

Test Plan:
- LATENCY=2: store addr 0x00000010, sel 1111, data 0xDEADBEEF -> `o_stall` high exactly 2 cycles, RESP pulse, word 4 = 0xDEADBEEF. Then load 0x10 -> `o_loadData`=0xDEADBEEF in RESP, `o_addrError`=0.
- Partial store to word 4, sel 0100, data 0x00AA0000 -> a subsequent load returns 0xDEAABEEF. A store with sel 0000 leaves 0xDEAABEEF.
- Out of range, DEPTH_LOG2=10: store to addr 0x00001000 -> `o_addrError`=1 with `o_respValid`, no write. A load from 0x00000000 is unchanged, and a load from 0x1000 returns 0 with `o_addrError`=1.
- LATENCY=1 and LATENCY=5: back-to-back loads -> stall widths 1 and 5. Gap: one cycle with `o_stall`=0 per RESP before the next request stalls.
- `rst` driven low during BUSY of a store of 0x12345678 to word 8 (prior value 0x0) -> outputs 0 immediately. After release the block is IDLE and a load of word 8 returns 0x0.
- Both enables high with data 0x55AA55AA to word 2 -> word 2 written, `o_loadData`=0. Changing `i_addr` mid-BUSY -> the latched address is used.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_responder_pkg
//
// Shared definitions for the multi-cycle data-memory responder:
//   - bus widths of the CPU data-memory interface
//   - responder FSM state encoding
//   - legal range of the LATENCY parameter and the counter type used to count
//     it down
//   - helper that decides whether a byte address lies outside the storage
// ---------------------------------------------------------------------------
package data_ram_responder_pkg;

  localparam int WORD_BUS     = 32;
  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_SEL_BUS  = 4;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  // Wide enough to hold LATENCY_MAX-2, the largest BUSY countdown start.
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // An address is out of range when any bit above the word index is set.
  // There is deliberately no wrap-around into the array.
  function automatic logic addr_out_of_range(
    input logic [MEM_ADDR_BUS-1:0] addr,
    input int                      depth_log2
  );
    return (addr >> (depth_log2 + 2)) != '0;
  endfunction

endpackage

// File: rtl/data_ram_responder_ram_word_array.sv
// ---------------------------------------------------------------------------
// ram_word_array
//
// Word-organised storage: 2^DEPTH_LOG2 words of WORD_BUS bits. A single index
// is shared by the synchronous, byte-lane-masked write port and the
// asynchronous read port. The array has no reset; its contents survive a
// reset of the surrounding responder.
//
// Ports:
//   clk           rising-edge clock for the write port
//   i_write_en    commit i_write_data to word i_index on this edge
//   i_index       word index for both read and write
//   i_sel         byte-lane enables; bit n writes bits [8n+7:8n]
//   i_write_data  lane-aligned write word
//   o_read_data   current contents of word i_index (combinational)
// ---------------------------------------------------------------------------
module ram_word_array
  import data_ram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   i_write_en,
  input  logic [DEPTH_LOG2-1:0]  i_index,
  input  logic [MEM_SEL_BUS-1:0] i_sel,
  input  logic [WORD_BUS-1:0]    i_write_data,
  output logic [WORD_BUS-1:0]    o_read_data
);

  logic [WORD_BUS-1:0] mem_q [0:(1 << DEPTH_LOG2)-1];

  // Only the enabled byte lanes change; the others keep their old contents.
  always_ff @(posedge clk) begin
    if (i_write_en) begin
      for (int b = 0; b < MEM_SEL_BUS; b++) begin
        if (i_sel[b]) begin
          mem_q[i_index][8*b +: 8] <= i_write_data[8*b +: 8];
        end
      end
    end
  end

  assign o_read_data = mem_q[i_index];

endmodule

// File: rtl/data_ram_responder.sv
// ---------------------------------------------------------------------------
// data_ram_responder
//
// Responder end of the CPU data-memory interface. A request (load or store)
// presented in IDLE is latched and the CPU is held with o_stall for LATENCY
// cycles in total, counting the cycle the request was presented. The
// following RESP cycle pulses o_respValid, returns the load word (registered)
// and, for stores, commits the selected byte lanes at the end of that cycle.
// Out-of-range addresses take the full latency, flag o_addrError in RESP,
// never write and return zero.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   i_readEnable   load request
//   i_writeEnable  store request (wins when both enables are high)
//   i_addr         byte address; bits [1:0] are ignored
//   i_sel          byte-lane enables for stores
//   i_storeData    lane-aligned store word
//   o_loadData     load word, valid only in the RESP cycle, otherwise 0
//   o_stall        CPU must hold its pipeline and the request stable
//   o_respValid    one-cycle completion pulse
//   o_addrError    one-cycle pulse with o_respValid for out-of-range requests
// ---------------------------------------------------------------------------
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_readEnable,
  input  logic                    i_writeEnable,
  input  logic [MEM_ADDR_BUS-1:0] i_addr,
  input  logic [MEM_SEL_BUS-1:0]  i_sel,
  input  logic [WORD_BUS-1:0]     i_storeData,
  output logic [WORD_BUS-1:0]     o_loadData,
  output logic                    o_stall,
  output logic                    o_respValid,
  output logic                    o_addrError
);

  // BUSY lasts LATENCY-1 cycles, so it starts counting down from LATENCY-2.
  localparam cnt_t CNT_INIT = (LATENCY >= 2) ? cnt_t'(LATENCY - 2) : '0;

  state_e                  state_q, state_d;
  cnt_t                    cnt_q, cnt_d;
  logic                    op_write_q, op_write_d;
  logic [DEPTH_LOG2-1:0]   index_q, index_d;
  logic [MEM_SEL_BUS-1:0]  sel_q, sel_d;
  logic [WORD_BUS-1:0]     data_q, data_d;
  logic                    oor_q, oor_d;
  logic [WORD_BUS-1:0]     load_data_q, load_data_d;

  logic                    req_in;
  logic                    oor_in;
  logic [DEPTH_LOG2-1:0]   index_in;
  logic                    req_write;
  logic                    req_oor;
  logic [DEPTH_LOG2-1:0]   ram_index;
  logic                    ram_we;
  logic [WORD_BUS-1:0]     ram_rdata;

  assign req_in   = i_readEnable | i_writeEnable;
  assign oor_in   = addr_out_of_range(i_addr, DEPTH_LOG2);
  assign index_in = i_addr[DEPTH_LOG2+1:2];

  // In IDLE the live inputs describe the request (needed when LATENCY==1 goes
  // straight to RESP); in every other state the latched copy is authoritative
  // so that inputs wiggling during BUSY have no effect.
  assign req_write = (state_q == IDLE) ? i_writeEnable : op_write_q;
  assign req_oor   = (state_q == IDLE) ? oor_in        : oor_q;
  assign ram_index = (state_q == IDLE) ? index_in      : index_q;

  // The write lands on the edge that leaves RESP, so a load accepted in the
  // next IDLE cycle already sees the new data.
  assign ram_we = (state_q == RESP) && op_write_q && !oor_q;

  ram_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk          (clk),
    .i_write_en   (ram_we),
    .i_index      (ram_index),
    .i_sel        (sel_q),
    .i_write_data (data_q),
    .o_read_data  (ram_rdata)
  );

  // State and latched-request registers; reset drops any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_write_q  <= 1'b0;
      index_q     <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      oor_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_write_q  <= op_write_d;
      index_q     <= index_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      oor_q       <= oor_d;
      load_data_q <= load_data_d;
    end
  end

  // Next-state logic, request capture and the registered load word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_write_d  = op_write_q;
    index_d     = index_q;
    sel_d       = sel_q;
    data_d      = data_q;
    oor_d       = oor_q;
    load_data_d = '0;

    unique case (state_q)
      IDLE: begin
        if (req_in) begin
          op_write_d = i_writeEnable;
          index_d    = index_in;
          sel_d      = i_sel;
          data_d     = i_storeData;
          oor_d      = oor_in;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture the full word on the edge into RESP for in-range loads only.
    if (state_d == RESP && !req_write && !req_oor) begin
      load_data_d = ram_rdata;
    end
  end

  // Handshake outputs. o_stall is gated by rst so it drops the moment reset
  // asserts, even if the CPU is still presenting a request.
  always_comb begin
    o_stall     = 1'b0;
    o_respValid = 1'b0;
    o_addrError = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_stall = rst & req_in;
      end
      BUSY: begin
        o_stall = 1'b1;
      end
      RESP: begin
        o_respValid = 1'b1;
        o_addrError = oor_q;
      end
      default: begin
        o_stall = 1'b0;
      end
    endcase
  end

  assign o_loadData = load_data_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_ram_responder
//
// Three responders (LATENCY 2, 1 and 5, DEPTH_LOG2 10) share clock and reset
// and have independent request buses. Index 0/1/2 in every array refers to
// the LATENCY 2/1/5 instance respectively.
// ---------------------------------------------------------------------------
module tb_data_ram_responder;

  logic        clk;
  logic        rst;
  logic        re_s    [3];
  logic        we_s    [3];
  logic [31:0] addr_s  [3];
  logic [3:0]  sel_s   [3];
  logic [31:0] data_s  [3];
  logic [31:0] ld_s    [3];
  logic        stall_s [3];
  logic        rv_s    [3];
  logic        ae_s    [3];

  int passed = 0;
  int total  = 0;

  // Reference storage: one 1024-word image per instance.
  logic [31:0] mem_model [3][1024];

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_ld;
    logic        exp_ae;
  } vec_t;

  vec_t vecs [13];

  data_ram_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst),
    .i_readEnable(re_s[0]), .i_writeEnable(we_s[0]), .i_addr(addr_s[0]),
    .i_sel(sel_s[0]), .i_storeData(data_s[0]),
    .o_loadData(ld_s[0]), .o_stall(stall_s[0]), .o_respValid(rv_s[0]),
    .o_addrError(ae_s[0])
  );

  data_ram_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .i_readEnable(re_s[1]), .i_writeEnable(we_s[1]), .i_addr(addr_s[1]),
    .i_sel(sel_s[1]), .i_storeData(data_s[1]),
    .o_loadData(ld_s[1]), .o_stall(stall_s[1]), .o_respValid(rv_s[1]),
    .o_addrError(ae_s[1])
  );

  data_ram_responder #(.DEPTH_LOG2(10), .LATENCY(5)) dut_l5 (
    .clk(clk), .rst(rst),
    .i_readEnable(re_s[2]), .i_writeEnable(we_s[2]), .i_addr(addr_s[2]),
    .i_sel(sel_s[2]), .i_storeData(data_s[2]),
    .o_loadData(ld_s[2]), .o_stall(stall_s[2]), .o_respValid(rv_s[2]),
    .o_addrError(ae_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int w);
    if (w == 0) return 2;
    if (w == 1) return 1;
    return 5;
  endfunction

  // Behavioural memory: out-of-range means anything at or above 4 KiB;
  // stores merge the selected bytes, loads return the whole word.
  function automatic void model_access(input int w, input logic wr, input logic rd,
                                       input logic [31:0] a, input logic [3:0] s,
                                       input logic [31:0] d,
                                       output logic [31:0] eld, output logic eae);
    logic oor;
    int   idx;
    oor = (a >= 32'h0000_1000);
    idx = int'((a % 32'h1000) / 4);
    eae = oor;
    eld = '0;
    if (wr) begin
      if (!oor) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mem_model[w][idx][8*b +: 8] = d[8*b +: 8];
        end
      end
    end else if (rd && !oor) begin
      eld = mem_model[w][idx];
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request on bus w at posedge+1 and holds it until the
  // response pulse. Returns the cycle index of RESP, the number of sampled
  // stall cycles (RESP included) and the response values.
  task automatic applyStimulus(input int w, input logic wr, input logic rd,
                               input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, input logic chg,
                               input logic [31:0] alt,
                               output int lat, output int stalls,
                               output logic [31:0] ld_o, output logic ae_o);
    re_s[w] = rd; we_s[w] = wr; addr_s[w] = a; sel_s[w] = s; data_s[w] = d;
    lat = -1; stalls = 0; ld_o = '0; ae_o = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall_s[w]) stalls++;
      if (rv_s[w]) begin
        lat = c; ld_o = ld_s[w]; ae_o = ae_s[w];
        break;
      end
      @(posedge clk); #1;
      if (c == 0 && chg) addr_s[w] = alt;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
    re_s[w] = 1'b0; we_s[w] = 1'b0; addr_s[w] = '0; sel_s[w] = '0; data_s[w] = '0;
  endtask

  // Runs one request and compares everything against the reference model.
  task automatic modelOp(input int w, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input string name);
    int          lat, stalls;
    logic [31:0] ld;
    logic        ae, eae;
    logic [31:0] eld;
    applyStimulus(w, wr, rd, a, s, d, 1'b0, '0, lat, stalls, ld, ae);
    model_access(w, wr, rd, a, s, d, eld, eae);
    checkOutput({name, "_lat"},    32'(lat),    32'(lat_of(w)));
    checkOutput({name, "_stalls"}, 32'(stalls), 32'(lat_of(w)));
    checkOutput({name, "_data"},   ld,          eld);
    checkOutput({name, "_aerr"},   32'(ae),     32'(eae));
  endtask

  initial begin
    int          lat, stalls;
    logic [31:0] ld, eld;
    logic        ae, eae;
    logic        wr, rd;
    logic [31:0] a;

    for (int w = 0; w < 3; w++) begin
      re_s[w] = 0; we_s[w] = 0; addr_s[w] = '0; sel_s[w] = '0; data_s[w] = '0;
    end
    rst = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 4'b0100, 32'h00AA_0000, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0010, 4'b0001, 32'h0,         32'hDEAA_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAA_BEEF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 4'b1111, 32'h0123_4567, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_1000, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,         32'h0123_4567, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_1000, 4'b0000, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_000C, 4'b1111, 32'h3333_3333, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0013, 4'b0000, 32'h0,         32'hDEAA_BEEF, 1'b0};

    // Reset values while rst is held low.
    #1;
    for (int w = 0; w < 3; w++) begin
      checkOutput($sformatf("reset_ld%0d", w),    ld_s[w],          32'h0);
      checkOutput($sformatf("reset_stall%0d", w), 32'(stall_s[w]),  32'h0);
      checkOutput($sformatf("reset_rv%0d", w),    32'(rv_s[w]),     32'h0);
      checkOutput($sformatf("reset_ae%0d", w),    32'(ae_s[w]),     32'h0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table on the LATENCY=2 instance.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].sel, vecs[i].data,
                    1'b0, '0, lat, stalls, ld, ae);
      model_access(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].sel, vecs[i].data, eld, eae);
      checkOutput($sformatf("vec%0d_lat", i),    32'(lat),    32'd2);
      checkOutput($sformatf("vec%0d_stalls", i), 32'(stalls), 32'd2);
      checkOutput($sformatf("vec%0d_data", i),   ld,          vecs[i].exp_ld);
      checkOutput($sformatf("vec%0d_aerr", i),   32'(ae),     32'(vecs[i].exp_ae));
    end

    // Both enables high is a store; the address moved mid-BUSY is ignored.
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0008, 4'b1111, 32'h55AA_55AA,
                  1'b1, 32'h0000_000C, lat, stalls, ld, ae);
    model_access(0, 1'b1, 1'b1, 32'h0000_0008, 4'b1111, 32'h55AA_55AA, eld, eae);
    checkOutput("both_en_lat",  32'(lat), 32'd2);
    checkOutput("both_en_data", ld,       32'h0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0008, 4'b0000, 32'h0, 1'b0, '0, lat, stalls, ld, ae);
    checkOutput("both_en_word2", ld, 32'h55AA_55AA);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_000C, 4'b0000, 32'h0, 1'b0, '0, lat, stalls, ld, ae);
    checkOutput("addr_change_word3", ld, 32'h3333_3333);

    // A load whose address changes mid-BUSY still returns the latched word.
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0010, 4'b0000, 32'h0,
                  1'b1, 32'h0000_0000, lat, stalls, ld, ae);
    checkOutput("load_addr_change", ld, 32'hDEAA_BEEF);

    // Reset during BUSY of a store to word 8: outputs drop, nothing commits.
    we_s[0] = 1'b1; addr_s[0] = 32'h0000_0020; sel_s[0] = 4'hF; data_s[0] = 32'h1234_5678;
    @(posedge clk); #1;
    checkOutput("rst_pre_stall", 32'(stall_s[0]), 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("rst_stall", 32'(stall_s[0]), 32'h0);
    checkOutput("rst_rv",    32'(rv_s[0]),    32'h0);
    checkOutput("rst_ae",    32'(ae_s[0]),    32'h0);
    checkOutput("rst_ld",    ld_s[0],         32'h0);
    @(negedge clk);
    we_s[0] = 1'b0; addr_s[0] = '0; sel_s[0] = '0; data_s[0] = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_idle_stall", 32'(stall_s[0]), 32'h0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0020, 4'b0000, 32'h0, 1'b0, '0, lat, stalls, ld, ae);
    checkOutput("post_rst_word8", ld, 32'h0);
    checkOutput("post_rst_lat",   32'(lat), 32'd2);

    // Latency 1 and 5: store then back-to-back loads.
    for (int w = 1; w < 3; w++) begin
      modelOp(w, 1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'hA5A5_0000 + 32'(w), $sformatf("lat%0d_st", lat_of(w)));
      for (int k = 0; k < 3; k++) begin
        modelOp(w, 1'b0, 1'b1, 32'h0000_0040, 4'h0, 32'h0, $sformatf("lat%0d_ld%0d", lat_of(w), k));
      end
    end

    // Randomised traffic over a small fully initialised window.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 16; i++) begin
        modelOp(w, 1'b1, 1'b0, 32'(i * 4), 4'hF, $urandom, $sformatf("rinit%0d_%0d", w, i));
      end
      for (int n = 0; n < 60; n++) begin
        wr = $urandom_range(0, 1) == 1;
        rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
        if ($urandom_range(0, 7) == 0) begin
          a = 32'h0000_1000 + ($urandom & 32'h0FFF_FFFF);
        end else begin
          a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        end
        modelOp(w, wr, rd, a, 4'($urandom_range(0, 15)), $urandom,
                $sformatf("rand%0d_%0d", w, n));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
